// File: rtl/aes_128_arbiter.sv
// Round-robin arbiter sharing one aes_128 core among NREQ requesters.
// Optional watchdog abort enabled by defining AES_ARB_WDOG_EN.
module aes_128_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][127:0] req_state,
  input  logic [NREQ-1:0][127:0] req_key,
  output logic                   core_rst,
  output logic                   core_start,
  output logic [127:0]           core_state,
  output logic [127:0]           core_key,
  input  logic                   core_done,
  input  logic [127:0]           core_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_err
);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t         st;
  logic [IDW-1:0] last;
  logic [IDW-1:0] win;
  logic           gnt_any;

  // Walk from the farthest candidate back to last+1 so the nearest valid one wins.
  always_comb begin
    gnt_any = 1'b0;
    win     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IDW'((int'(last) + k) % NREQ)]) begin
        gnt_any = 1'b1;
        win     = IDW'((int'(last) + k) % NREQ);
      end
    end
  end

  assign req_ready = (st == IDLE && gnt_any) ? (NREQ'(1) << win) : '0;

`ifdef AES_ARB_WDOG_EN
  logic [7:0] wd_cnt;
  logic       rsp_err_q;
  logic       wd_fire;

  // A done arriving on the timeout cycle takes priority over the abort.
  assign wd_fire  = (st == RUN) && !core_done && (wd_cnt == 8'(TIMEOUT));
  assign core_rst = rst | wd_fire;
  assign rsp_err  = rsp_err_q;
`else
  assign core_rst = rst;
  assign rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      last       <= IDW'(NREQ - 1);
      core_start <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      core_state <= '0;
      core_key   <= '0;
`ifdef AES_ARB_WDOG_EN
      wd_cnt     <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      case (st)
        IDLE: if (gnt_any) begin
          // Only place the core operands change; they hold until the next grant.
          core_state <= req_state[win];
          core_key   <= req_key[win];
          last       <= win;
          rsp_id     <= win;
          core_start <= 1'b1;
          st         <= START;
`ifdef AES_ARB_WDOG_EN
          rsp_err_q  <= 1'b0;
`endif
        end
        START: begin
          st <= RUN;
`ifdef AES_ARB_WDOG_EN
          wd_cnt <= '0;
`endif
        end
        RUN: if (core_done) begin
          rsp_data  <= core_out;
          rsp_valid <= 1'b1;
          st        <= RESP;
        end
`ifdef AES_ARB_WDOG_EN
        else if (wd_fire) begin
          rsp_data  <= '0;
          rsp_err_q <= 1'b1;
          rsp_valid <= 1'b1;
          st        <= RESP;
        end else begin
          wd_cnt <= wd_cnt + 8'd1;
        end
`endif
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_arbiter.sv
// Scoreboard bench for aes_128_arbiter with a fixed-latency core stub.
module tb_aes_128_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 40;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][127:0] req_state;
  logic [NREQ-1:0][127:0] req_key;
  logic                   core_rst, core_start, core_done;
  logic [127:0]           core_state, core_key, core_out;
  logic                   rsp_valid, rsp_ready, rsp_err;
  logic [127:0]           rsp_data;
  logic [IDW-1:0]         rsp_id;

  aes_128_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(48)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_key(req_key),
    .core_rst(core_rst), .core_start(core_start),
    .core_state(core_state), .core_key(core_key),
    .core_done(core_done), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // Core stub: real ciphertext for the FIPS vector, a cheap keyed mix otherwise.
  function automatic logic [127:0] aes_stub(input logic [127:0] pt, input logic [127:0] key);
    if (key == FKEY && pt == FPT) return FCT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  logic       stall = 1'b0;
  logic       cbusy;
  logic [7:0] ccnt;
  always @(posedge clk) begin
    if (core_rst) begin
      cbusy <= 1'b0; ccnt <= 8'd0;
    end else if (core_start) begin
      cbusy <= 1'b1; ccnt <= 8'd1;
    end else if (cbusy) begin
      if (ccnt == 8'(LAT)) cbusy <= 1'b0;
      else ccnt <= ccnt + 8'd1;
    end
  end
  assign core_done = cbusy && ccnt == 8'(LAT) && !stall;
  assign core_out  = aes_stub(core_state, core_key);

  typedef struct packed {
    logic [127:0]   d;
    logic [IDW-1:0] id;
    logic           err;
  } exp_t;
  exp_t q[$];

  int nvec = 0, nmis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [127:0] d, input int id, input logic err);
    exp_t e;
    e.d = d; e.id = IDW'(id); e.err = err;
    return e;
  endfunction

  // Monitor: scoreboard pops, latency, core operand stability, watchdog pulses.
  int           hs_cyc = 0, lat = 0, rise_cyc = 0, rv_cnt = 0;
  int           crst_n = 0, crst_cyc = 0, stab_bad = 0;
  logic         rv_q = 1'b0, injob = 1'b0;
  logic [255:0] snap = '0;
  initial forever begin
    @(negedge clk);
    if (|(req_ready & req_valid)) hs_cyc = cyc;
    if (rsp_valid && !rv_q) begin lat = cyc - hs_cyc; rise_cyc = cyc; end
    rv_q = rsp_valid;
    if (rsp_valid) rv_cnt++;
    if (core_rst && !rst) begin crst_n++; crst_cyc = cyc; end
    if (rst) injob = 1'b0;
    else if (core_start) begin snap = {core_state, core_key}; injob = 1'b1; end
    else if (injob && {core_state, core_key} != snap) stab_bad++;
    if (rsp_valid && rsp_ready) begin
      injob = 1'b0;
      if (q.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_rsp: got id %0d data %h, expected no response", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp", {rsp_data ^ e.d, 125'd0, rsp_id != e.id, rsp_err != e.err} == '0 ? 128'd0 : rsp_data,
            {rsp_data ^ e.d, 125'd0, rsp_id != e.id, rsp_err != e.err} == '0 ? 128'd0 : e.d);
        if (rsp_id !== e.id || rsp_err !== e.err)
          $display("FAIL rsp_tag: got id %0d err %0d expected id %0d err %0d", rsp_id, rsp_err, e.id, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int i, input logic [127:0] pt, input logic [127:0] key);
    logic ok;
    ok = 1'b0;
    req_valid[i] = 1'b1; req_state[i] = pt; req_key[i] = key;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
    tick();
    req_valid[i] = 1'b0;
    if (!ok) begin
      nvec++; nmis++;
      $display("FAIL grant_timeout: req %0d never saw ready, expected a grant", i);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && q.size() != 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      nvec++; nmis++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
    tick(); tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"},  128'(req_ready), 128'd0);
    chk({tag, "_core_start"}, 128'(core_start), 128'd0);
    chk({tag, "_rsp_valid"},  128'(rsp_valid), 128'd0);
    chk({tag, "_rsp_err"},    128'(rsp_err), 128'd0);
    chk({tag, "_rsp_data"},   rsp_data, 128'd0);
    chk({tag, "_rsp_id"},     128'(rsp_id), 128'd0);
    chk({tag, "_core_state"}, core_state, 128'd0);
    chk({tag, "_core_key"},   core_key, 128'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  function automatic logic [127:0] pt_of(input int i);
    return {4{32'h1000_0001 * (i + 1)}};
  endfunction
  function automatic logic [127:0] key_of(input int i);
    return {16{8'h3c + 8'(i)}};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int grants, prev, space_bad, bad, rv0, cr0;
    logic [127:0] sd;
    logic [IDW-1:0] sid;
    rst = 1'b1; req_valid = '0; req_state = '0; req_key = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset("reset");

    // FIPS-197 vector on requester 2 alone.
    q.push_back(mk(FCT, 2, 1'b0));
    issue(2, FPT, FKEY);
    drain();
    chk("fips_latency", 128'(lat), 128'(LAT + 2));

    // All requesters continuously valid: 0,1,2,3,0,1 at minimum spacing.
    pulse_rst();
    for (int i = 0; i < NREQ; i++) begin
      req_state[i] = pt_of(i); req_key[i] = key_of(i);
    end
    for (int j = 0; j < 6; j++) q.push_back(mk(aes_stub(pt_of(j % 4), key_of(j % 4)), j % 4, 1'b0));
    req_valid = '1;
    grants = 0; prev = 0; space_bad = 0;
    for (int n = 0; n < 600 && grants < 6; n++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) begin
        if (grants > 0 && cyc - prev != LAT + 3) space_bad++;
        prev = cyc;
        grants++;
        if (grants == 6) begin tick(); req_valid = '0; end
      end
    end
    chk("rr_grants", 128'(grants), 128'd6);
    chk("rr_spacing_bad", 128'(space_bad), 128'd0);
    drain();
    chk("key_stable_bad", 128'(stab_bad), 128'd0);

    // Backpressure: hold the response 20 cycles while requester 3 waits.
    rsp_ready = 1'b0;
    q.push_back(mk(aes_stub(pt_of(1), key_of(1)), 1, 1'b0));
    q.push_back(mk(aes_stub(pt_of(3), key_of(3)), 3, 1'b0));
    issue(1, pt_of(1), key_of(1));
    req_valid[3] = 1'b1; req_state[3] = pt_of(3); req_key[3] = key_of(3);
    for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clk);
    chk("bp_valid", 128'(rsp_valid), 128'd1);
    sd = rsp_data; sid = rsp_id; bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data != sd || rsp_id != sid || req_ready != '0) bad++;
    end
    chk("bp_hold_bad", 128'(bad), 128'd0);
    tick();
    rsp_ready = 1'b1;
    for (int n = 0; n < 20 && !req_ready[3]; n++) @(negedge clk);
    chk("bp_next_grant", 128'(req_ready), 128'b1000);
    tick();
    req_valid[3] = 1'b0;
    drain();

    // Reset ten cycles into RUN drops the job.
    issue(2, pt_of(2), key_of(2));
    repeat (11) tick();
    pulse_rst();
    chk_reset("midrst");
    rv0 = rv_cnt;
    repeat (60) tick();
    chk("midrst_no_rsp", 128'(rv_cnt - rv0), 128'd0);
    q.push_back(mk(aes_stub(pt_of(0), key_of(0)), 0, 1'b0));
    issue(0, pt_of(0), key_of(0));
    drain();

    // Core that never finishes.
    stall = 1'b1;
    cr0 = crst_n;
`ifdef AES_ARB_WDOG_EN
    q.push_back(mk(128'd0, 1, 1'b1));
    issue(1, pt_of(1), key_of(1));
    drain();
    stall = 1'b0;
    chk("wdog_latency", 128'(lat), 128'(LAT + 11));
    chk("wdog_core_rst_pulses", 128'(crst_n - cr0), 128'd1);
    chk("wdog_core_rst_cycle", 128'(rise_cyc - crst_cyc), 128'd1);
    q.push_back(mk(aes_stub(pt_of(0), key_of(0)), 0, 1'b0));
    issue(0, pt_of(0), key_of(0));
    drain();
`else
    rv0 = rv_cnt;
    issue(1, pt_of(1), key_of(1));
    req_valid[0] = 1'b1; req_state[0] = pt_of(0); req_key[0] = key_of(0);
    bad = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (req_ready != '0) bad++;
    end
    chk("stall_no_grant", 128'(bad), 128'd0);
    chk("stall_no_rsp", 128'(rv_cnt - rv0), 128'd0);
    chk("stall_no_core_rst", 128'(crst_n - cr0), 128'd0);
    stall = 1'b0;
    q.push_back(mk(aes_stub(pt_of(0), key_of(0)), 0, 1'b0));
    pulse_rst();
    for (int n = 0; n < 20 && !req_ready[0]; n++) @(negedge clk);
    tick();
    req_valid[0] = 1'b0;
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
